// File: rtl/usrt_txq.sv
// USRT transmit channel: write-side FIFO feeding a start/data/parity/stop framing shifter.
// All transitions are paced by the one-cycle baud tick i_Bclk.
module usrt_txq #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        i_Pclk,
    input  logic                        i_Presetn,
    input  logic                        i_Bclk,
    input  logic                        i_Enable,
    input  logic                        i_Parity_En,
    input  logic                        i_Parity_Odd,
    input  logic                        i_Two_Stop,
    input  logic                        i_Wr,
    input  logic [DATA_W-1:0]           i_Data,
    output logic                        o_Tx_Serial,
    output logic                        o_Full,
    output logic                        o_Empty,
    output logic [$clog2(FIFO_DEPTH):0] o_Level,
    output logic                        o_Ovf,
    output logic                        o_Busy,
    output logic                        o_Pready
);

    localparam int unsigned PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DepthLvl = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       level_q, level_d;
    logic              full_q, empty_q, ovf_q;
    logic              push, pop;
    logic [DATA_W-1:0] head;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              two_stop_q, two_stop_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              pready_q, pready_d;
    logic              can_pop;

    assign push    = i_Wr & ~full_q;
    assign head    = mem[rd_ptr_q];
    assign level_d = level_q + (PW + 1)'(push) - (PW + 1)'(pop);
    // Empty is the registered flag, so a word written this cycle cannot be popped this cycle.
    assign can_pop = i_Enable & ~empty_q;

    always_ff @(posedge i_Pclk) begin
        if (push) mem[wr_ptr_q] <= i_Data;
    end

    always_ff @(posedge i_Pclk or negedge i_Presetn) begin
        if (!i_Presetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            full_q  <= (level_d == DepthLvl);
            empty_q <= (level_d == '0);
            ovf_q   <= i_Wr & full_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        pready_d   = 1'b0;
        pop        = 1'b0;
        if (i_Bclk) begin
            unique case (state_q)
                StIdle: begin
                    if (can_pop) begin
                        pop     = 1'b1;
                        state_d = StStart;
                        tx_d    = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                StStart: begin
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = StData;
                end
                StData: begin
                    if (bit_cnt_q == 4'(DATA_W - 1)) begin
                        stop_cnt_d = 1'b0;
                        if (par_en_q) begin
                            state_d = StParity;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                StParity: begin
                    state_d    = StStop;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
                StStop: begin
                    if (two_stop_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        pready_d = 1'b1;
                        if (can_pop) begin
                            pop     = 1'b1;
                            state_d = StStart;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = StIdle;
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
        // Frame format is frozen at pop time; later config changes affect the next frame only.
        if (pop) begin
            shreg_d    = head;
            par_en_d   = i_Parity_En;
            par_bit_d  = (^head) ^ i_Parity_Odd;
            two_stop_d = i_Two_Stop;
        end
    end

    always_ff @(posedge i_Pclk or negedge i_Presetn) begin
        if (!i_Presetn) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            pready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            pready_q   <= pready_d;
        end
    end

    assign o_Tx_Serial = tx_q;
    assign o_Full      = full_q;
    assign o_Empty     = empty_q;
    assign o_Level     = level_q;
    assign o_Ovf       = ovf_q;
    assign o_Busy      = busy_q;
    assign o_Pready    = pready_q;

endmodule

// File: tb/tb_usrt_txq.sv
// Directed bench for usrt_txq: framing formats, FIFO full/overflow, back-to-back frames,
// enable drop, mid-frame config change and asynchronous reset.
module tb_usrt_txq;

    logic       i_Pclk = 1'b0;
    logic       i_Presetn, i_Bclk, i_Enable, i_Parity_En, i_Parity_Odd, i_Two_Stop, i_Wr;
    logic [7:0] i_Data;
    logic       o_Tx_Serial, o_Full, o_Empty, o_Ovf, o_Busy, o_Pready;
    logic [2:0] o_Level;

    int tests = 0;
    int fails = 0;

    usrt_txq #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .i_Pclk      (i_Pclk),
        .i_Presetn   (i_Presetn),
        .i_Bclk      (i_Bclk),
        .i_Enable    (i_Enable),
        .i_Parity_En (i_Parity_En),
        .i_Parity_Odd(i_Parity_Odd),
        .i_Two_Stop  (i_Two_Stop),
        .i_Wr        (i_Wr),
        .i_Data      (i_Data),
        .o_Tx_Serial (o_Tx_Serial),
        .o_Full      (o_Full),
        .o_Empty     (o_Empty),
        .o_Level     (o_Level),
        .o_Ovf       (o_Ovf),
        .o_Busy      (o_Busy),
        .o_Pready    (o_Pready)
    );

    always #5 i_Pclk = ~i_Pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_Pclk);
        #1;
    endtask

    // Two idle cycles, then a one-cycle tick; returns #1 after the tick edge.
    task automatic do_tick();
        cyc();
        cyc();
        i_Bclk = 1'b1;
        cyc();
        i_Bclk = 1'b0;
    endtask

    task automatic write(input logic [7:0] d);
        i_Wr   = 1'b1;
        i_Data = d;
        cyc();
        i_Wr   = 1'b0;
    endtask

    // seq holds the expected line bits, first-transmitted bit at seq[len-1].
    task automatic check_frame(input string tag, input logic [11:0] seq, input int len,
                               input logic pr_first, input int act_at, input int act);
        for (int i = 0; i < len; i++) begin
            if (i == act_at) begin
                case (act)
                    1: i_Enable = 1'b0;
                    2: begin
                        i_Parity_En = 1'b1;
                        i_Two_Stop  = 1'b1;
                    end
                    default: ;
                endcase
            end
            do_tick();
            check($sformatf("%s bit%0d", tag, i), o_Tx_Serial, seq[len-1-i]);
            if (i == 0) begin
                check({tag, " busy"}, o_Busy, 1'b1);
                check({tag, " pready_first"}, o_Pready, pr_first);
            end
        end
    endtask

    task automatic end_frame(input string tag);
        do_tick();
        check({tag, " end tx"}, o_Tx_Serial, 1'b1);
        check({tag, " end pready"}, o_Pready, 1'b1);
        cyc();
        check({tag, " end pready clr"}, o_Pready, 1'b0);
        check({tag, " end busy"}, o_Busy, 1'b0);
    endtask

    initial begin
        i_Presetn = 1'b0;
        i_Bclk = 1'b0; i_Enable = 1'b0; i_Wr = 1'b0; i_Data = '0;
        i_Parity_En = 1'b0; i_Parity_Odd = 1'b0; i_Two_Stop = 1'b0;
        #23 i_Presetn = 1'b1;
        cyc();
        check("rst tx", o_Tx_Serial, 1'b1);
        check("rst empty", o_Empty, 1'b1);
        check("rst full", o_Full, 1'b0);
        check("rst level", o_Level, 3'd0);
        check("rst ovf", o_Ovf, 1'b0);
        check("rst busy", o_Busy, 1'b0);
        check("rst pready", o_Pready, 1'b0);

        // 0x53, 8N1
        i_Enable = 1'b1;
        write(8'h53);
        check("w53 level", o_Level, 3'd1);
        check("w53 empty", o_Empty, 1'b0);
        check_frame("8N1", 12'b0110010101, 10, 1'b0, -1, 0);
        end_frame("8N1");
        check("8N1 empty", o_Empty, 1'b1);

        // 0x53 even parity, odd parity, even parity + two stop
        i_Parity_En = 1'b1;
        write(8'h53);
        check_frame("8E1", 12'b01100101001, 11, 1'b0, -1, 0);
        end_frame("8E1");
        i_Parity_Odd = 1'b1;
        write(8'h53);
        check_frame("8O1", 12'b01100101011, 11, 1'b0, -1, 0);
        end_frame("8O1");
        i_Parity_Odd = 1'b0;
        i_Two_Stop   = 1'b1;
        write(8'h53);
        check_frame("8E2", 12'b011001010011, 12, 1'b0, -1, 0);
        end_frame("8E2");

        // Fill FIFO with enable low; fifth write overflows
        i_Parity_En = 1'b0;
        i_Two_Stop  = 1'b0;
        i_Enable    = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            write(8'(k));
            if (k == 4) begin
                check("fill full", o_Full, 1'b1);
                check("fill level", o_Level, 3'd4);
                check("fill ovf0", o_Ovf, 1'b0);
            end
            if (k == 5) begin
                check("ovf pulse", o_Ovf, 1'b1);
                check("ovf level", o_Level, 3'd4);
            end
        end
        cyc();
        check("ovf clr", o_Ovf, 1'b0);
        i_Enable = 1'b1;
        check_frame("q01", 12'b0100000001, 10, 1'b0, -1, 0);
        check_frame("q02", 12'b0010000001, 10, 1'b1, -1, 0);
        check_frame("q03", 12'b0110000001, 10, 1'b1, -1, 0);
        check_frame("q04", 12'b0001000001, 10, 1'b1, -1, 0);
        end_frame("q04");
        check("q empty", o_Empty, 1'b1);
        do_tick();
        check("q no 05", o_Tx_Serial, 1'b1);
        check("q level", o_Level, 3'd0);

        // Drop enable during data bits of frame 1
        i_Enable = 1'b0;
        write(8'hA5);
        write(8'h3C);
        i_Enable = 1'b1;
        check_frame("enA5", 12'b0101001011, 10, 1'b0, 3, 1);
        end_frame("enA5");
        check("en level", o_Level, 3'd1);
        do_tick();
        check("en idle", o_Tx_Serial, 1'b1);
        i_Enable = 1'b1;
        check_frame("en3C", 12'b0001111001, 10, 1'b0, -1, 0);
        end_frame("en3C");

        // Config change mid-frame applies to next frame only
        write(8'h53);
        write(8'h53);
        check_frame("cfg1", 12'b0110010101, 10, 1'b0, 4, 2);
        check_frame("cfg2", 12'b011001010011, 12, 1'b1, -1, 0);
        end_frame("cfg2");

        // Asynchronous reset during data bits
        i_Parity_En = 1'b0;
        i_Two_Stop  = 1'b0;
        write(8'h53);
        write(8'h53);
        for (int i = 0; i < 4; i++) do_tick();
        check("rst pre tx", o_Tx_Serial, 1'b0);
        #2 i_Presetn = 1'b0;
        #1;
        check("arst tx", o_Tx_Serial, 1'b1);
        check("arst level", o_Level, 3'd0);
        check("arst busy", o_Busy, 1'b0);
        check("arst empty", o_Empty, 1'b1);
        #3 i_Presetn = 1'b1;
        cyc();
        write(8'hA5);
        check_frame("post", 12'b0101001011, 10, 1'b0, -1, 0);
        end_frame("post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
